i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Shares the single-byte I2C master between up to `NUM_REQ` on-chip requesters.
- Each requester presents a slave address, R/W bit and write byte.
- The block grants requesters round-robin and issues exactly one single-byte transaction to the master per grant.
- It waits for the master to complete, then returns read data and ACK/NACK status to the winning requester.
- It sits between the system-side requesters and the I2C master, and is the only block that drives the master's command inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in `clk` cycles. Used only when `I2C_ARB_TIMEOUT_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `i_req`  in  `NUM_REQ`: per-requester request level.
- `i_Slave_Add`  in  `NUM_REQ*7`: per-requester 7-bit slave address; requester k occupies bits [7k+6:7k].
- `i_RW`  in  `NUM_REQ`: per-requester direction; 1 = read, 0 = write.
- `i_DATA`  in  `NUM_REQ*8`: per-requester write byte, bits [8k+7:8k].
- `o_gnt`  out  `NUM_REQ`: one-hot grant, held high for the whole transaction.
- `o_done`  out  `NUM_REQ`: one-hot, one-cycle completion pulse.
- `o_err`  out  1: status for the completing transaction (NACK or timeout); valid only while `o_done` is non-zero.
- `o_RD_DATA`  out  8: read byte; valid only while `o_done` is non-zero.
- `o_m_start`  out  1: one-cycle start pulse to the master.
- `o_m_Slave_Add`  out  7: address to the master.
- `o_m_RW`  out  1: direction to the master.
- `o_m_DATA`  out  8: write byte to the master.
- `i_m_busy`  in  1: master is mid-transaction.
- `i_m_done`  in  1: master completion pulse, one cycle.
- `i_m_nack`  in  1: slave NACKed; sampled with `i_m_done`.
- `i_m_RD_DATA`  in  8: master read byte; sampled with `i_m_done`.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Arbitrates only when `i_req` is non-zero and `i_m_busy` is 0.
  - Winner is the first set bit searching from `last+1` upward, wrapping modulo `NUM_REQ`.
  - On a winner: register winner index, address, RW and data into the `o_m_*` outputs; assert `o_gnt[winner]`; go to ISSUE.
- **ISSUE**
  - `o_m_start` = 1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - Hold `o_gnt` and all `o_m_*` outputs stable.
  - When `i_m_done` = 1:
    - capture `o_err` = `i_m_nack`;
    - capture `o_RD_DATA` = `i_m_RD_DATA` when RW = 1, else 0x00;
    - go to RESP.
- **RESP**
  - `o_done[winner]` = 1 for one cycle.
  - `last` = winner.
  - Deassert `o_gnt`.
  - Return to IDLE.

Rules:
- Requester fields are sampled once, in IDLE. Changes after the grant are ignored.
- A requester that drops `i_req` mid-transaction still receives its `o_done` pulse.
- A requester holding `i_req` after its `o_done` re-enters arbitration at normal round-robin priority. It does not win back-to-back while others are requesting.
- `i_m_done` outside WAIT is ignored. No error is raised.

## Timing
Reset values:
- All outputs are 0.
- State is IDLE.
- `last` = `NUM_REQ-1`, so requester 0 has first priority after reset.

Latencies:
- `i_req` high in IDLE at cycle N (master idle) → `o_gnt` high at N+1 (ISSUE), `o_m_start` at N+1.
- `i_m_done` at cycle M → `o_done` at M+1 → IDLE at M+2.
- Earliest next grant is at M+3.
- Minimum request-to-done overhead, excluding master time, is 3 cycles.

Boundary conditions:
- Simultaneous requests: exactly one grant, by round-robin order.
- `i_m_done` in the same cycle as ISSUE is ignored. The master must not complete in fewer than 2 cycles after start.
- `rst_n` low mid-transaction: all outputs clear immediately. No `o_done` is issued for the aborted transaction. The master is expected to share the same reset.

## Configuration
`I2C_ARB_TIMEOUT_EN`:
- **Defined:** a counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching `TIMEOUT_CYCLES-1` without `i_m_done` forces RESP with `o_err` = 1 and `o_RD_DATA` = 0x00.
  - The winner is released and `last` updates as normal.
- **Undefined:** no counter. WAIT holds indefinitely until `i_m_done`.

## Test plan
- **Single write:** req0 with addr 0x55, RW = 0, data 0x07; master done 20 cycles after start with nack = 0. Required:
  - `o_m_Slave_Add` = 0x55, `o_m_DATA` = 0x07, one `o_m_start` pulse;
  - `o_done[0]` one cycle after `i_m_done`, `o_err` = 0, `o_RD_DATA` = 0x00.
- **Read:** req2 with RW = 1, master returns 0xA5. Required: `o_done[2]` with `o_RD_DATA` = 0xA5.
- **Round-robin:** `i_req` = 4'b1111 held continuously. Required grants in order 0, 1, 2, 3, 0; never the same requester twice in a row.
- **NACK:** master done with `i_m_nack` = 1. Required: `o_err` = 1 on the `o_done` cycle, then the next request is served normally.
- **Busy / reset:**
  - `i_m_busy` = 1 in IDLE with req1 pending → no grant until busy drops.
  - `rst_n` asserted during WAIT → all outputs 0 that cycle; no `o_done`; requester 0 is served first afterwards.
- **Timeout** (`I2C_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): master never completes. Required:
  - `o_done` exactly 16 cycles after WAIT entry, with `o_err` = 1;
  - without the macro, no `o_done` within 1000 cycles.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
`default_nettype none
// i2c_txn_arbiter_if: requester-side and I2C-master-side signals of the transaction arbiter.
// Rev 1.0
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*7-1:0] i_Slave_Add;
  logic [NUM_REQ-1:0]   i_RW;
  logic [NUM_REQ*8-1:0] i_DATA;
  logic [NUM_REQ-1:0]   o_gnt;
  logic [NUM_REQ-1:0]   o_done;
  logic                 o_err;
  logic [7:0]           o_RD_DATA;
  logic                 o_m_start;
  logic [6:0]           o_m_Slave_Add;
  logic                 o_m_RW;
  logic [7:0]           o_m_DATA;
  logic                 i_m_busy;
  logic                 i_m_done;
  logic                 i_m_nack;
  logic [7:0]           i_m_RD_DATA;

  // master = the arbiter itself; slave = the surrounding requesters and I2C master
  modport master (
    input  i_req, i_Slave_Add, i_RW, i_DATA, i_m_busy, i_m_done, i_m_nack, i_m_RD_DATA,
    output o_gnt, o_done, o_err, o_RD_DATA, o_m_start, o_m_Slave_Add, o_m_RW, o_m_DATA
  );
  modport slave (
    output i_req, i_Slave_Add, i_RW, i_DATA, i_m_busy, i_m_done, i_m_nack, i_m_RD_DATA,
    input  o_gnt, o_done, o_err, o_RD_DATA, o_m_start, o_m_Slave_Add, o_m_RW, o_m_DATA
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// i2c_txn_arbiter: round-robin sharing of one single-byte I2C master among NUM_REQ requesters.
// Rev 1.0 -- optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst_n,
  i2c_txn_arbiter_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last, win, pick_idx, cand;
  logic               pick_ok;
  logic               wd_expired;
  logic [NUM_REQ-1:0] win_oh;
  logic [6:0]         sel_addr, m_addr;
  logic               sel_rw, m_rw;
  logic [7:0]         sel_data, m_data;
  logic               err;
  logic [7:0]         rd_data;

  // Round-robin search starting just above the previous winner
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!pick_ok && bus.i_req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_addr = bus.i_Slave_Add[7*k +: 7];
        sel_rw   = bus.i_RW[k];
        sel_data = bus.i_DATA[8*k +: 8];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wd_cnt;

  // Counter sits at zero outside WAIT, so it is zero on every WAIT entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_ok && !bus.i_m_busy) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.i_m_done || wd_expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= IDX_W'(NUM_REQ - 1);
      win     <= '0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_data  <= '0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == ISSUE) begin
            win    <= pick_idx;
            m_addr <= sel_addr;
            m_rw   <= sel_rw;
            m_data <= sel_data;
          end
        end
        WAIT: begin
          // A genuine completion wins over a watchdog expiry in the same cycle
          if (bus.i_m_done) begin
            err     <= bus.i_m_nack;
            rd_data <= m_rw ? bus.i_m_RD_DATA : 8'h00;
          end else if (wd_expired) begin
            err     <= 1'b1;
            rd_data <= 8'h00;
          end
        end
        RESP:    last <= win;
        default: ;
      endcase
    end
  end

  assign win_oh            = NUM_REQ'(1) << win;
  assign bus.o_gnt         = (state == ISSUE || state == WAIT) ? win_oh : '0;
  assign bus.o_done        = (state == RESP) ? win_oh : '0;
  assign bus.o_err         = err;
  assign bus.o_RD_DATA     = rd_data;
  assign bus.o_m_start     = (state == ISSUE);
  assign bus.o_m_Slave_Add = m_addr;
  assign bus.o_m_RW        = m_rw;
  assign bus.o_m_DATA      = m_data;
endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// tb_i2c_txn_arbiter: directed table, hand sequences and randomized transactions for i2c_txn_arbiter.
// Rev 1.0
module tb_i2c_txn_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  int   mlast  = 3;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NUM_REQ(4)) bus ();

  i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       nack;
    logic [7:0] mrd;
    int         lat;
    int         exp_w;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t tbl [8];
  int   rr_exp [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Round-robin rule: first requesting index above the previous winner, wrapping
  function automatic int pick(input logic [3:0] r, input int l);
    for (int i = 1; i <= 4; i++) if (r[(l + i) % 4]) return (l + i) % 4;
    return -1;
  endfunction

  function automatic logic [33:0] all_outs();
    return {bus.o_gnt, bus.o_done, bus.o_err, bus.o_RD_DATA, bus.o_m_start,
            bus.o_m_Slave_Add, bus.o_m_RW, bus.o_m_DATA};
  endfunction

  task automatic clear_inputs();
    bus.i_req = '0; bus.i_Slave_Add = '0; bus.i_RW = '0; bus.i_DATA = '0;
    bus.i_m_busy = 1'b0; bus.i_m_done = 1'b0; bus.i_m_nack = 1'b0; bus.i_m_RD_DATA = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mlast = 3;
    @(negedge clk);
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (bus.o_gnt == 4'b0 && n < 20) begin @(negedge clk); n++; end
  endtask

  // Full transaction: called at a negedge, returns at the negedge of the o_done cycle
  task automatic txn(input logic [3:0] req, input logic [27:0] addrs, input logic [3:0] rws,
                     input logic [31:0] datas, input logic nack, input logic [7:0] mrd,
                     input int lat, input int w, input logic [7:0] exp_rd, input logic exp_err,
                     input bit hold);
    int         starts;
    bit         early;
    logic [6:0] ea;
    logic [7:0] ed;
    ea = addrs[7*w +: 7];
    ed = datas[8*w +: 8];
    bus.i_req = req; bus.i_Slave_Add = addrs; bus.i_RW = rws; bus.i_DATA = datas;
    wait_gnt();
    chk("gnt", bus.o_gnt, 64'd1 << w);
    chk("start", bus.o_m_start, 1);
    chk("m_fields", {bus.o_m_Slave_Add, bus.o_m_RW, bus.o_m_DATA}, {ea, rws[w], ed});
    bus.i_Slave_Add = ~addrs; bus.i_RW = ~rws; bus.i_DATA = ~datas;
    if (!hold) bus.i_req = '0;
    starts = 0;
    early  = 0;
    repeat (lat) begin
      @(negedge clk);
      starts += int'(bus.o_m_start);
      if (bus.o_done != 0) early = 1;
    end
    chk("held", {bus.o_gnt, bus.o_m_Slave_Add, bus.o_m_RW, bus.o_m_DATA},
        {4'(1 << w), ea, rws[w], ed});
    bus.i_m_done = 1'b1; bus.i_m_nack = nack; bus.i_m_RD_DATA = mrd;
    @(negedge clk);
    bus.i_m_done = 1'b0; bus.i_m_nack = 1'b0; bus.i_m_RD_DATA = 8'($urandom);
    chk("done", bus.o_done, 64'd1 << w);
    chk("err_rd", {bus.o_err, bus.o_RD_DATA}, {exp_err, exp_rd});
    chk("single_start", {starts != 0, early}, 0);
    mlast = w;
  endtask

  initial begin
    logic [3:0]  rq, rw;
    logic [27:0] ad;
    logic [31:0] dt;
    logic [7:0]  md;
    logic        nk;
    int          w;
    bit          seen;
    int          n;

    tbl[0] = '{4'b0001, 7'h55, 1'b0, 8'h07, 1'b0, 8'h3C, 20, 0, 8'h00, 1'b0};
    tbl[1] = '{4'b0100, 7'h12, 1'b1, 8'h00, 1'b0, 8'hA5,  5, 2, 8'hA5, 1'b0};
    tbl[2] = '{4'b0011, 7'h2A, 1'b0, 8'h99, 1'b1, 8'h77,  3, 0, 8'h00, 1'b1};
    tbl[3] = '{4'b0011, 7'h2B, 1'b0, 8'h11, 1'b0, 8'h00,  2, 1, 8'h00, 1'b0};
    tbl[4] = '{4'b1001, 7'h40, 1'b1, 8'h00, 1'b0, 8'hC3,  4, 3, 8'hC3, 1'b0};
    tbl[5] = '{4'b1001, 7'h41, 1'b1, 8'h00, 1'b0, 8'h3C,  2, 0, 8'h3C, 1'b0};
    tbl[6] = '{4'b1110, 7'h7F, 1'b1, 8'h00, 1'b1, 8'hFF,  6, 1, 8'hFF, 1'b1};
    tbl[7] = '{4'b1000, 7'h08, 1'b0, 8'hE1, 1'b0, 8'h5A,  2, 3, 8'h00, 1'b0};

    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("reset_outputs", all_outs(), 0);
    do_reset();

    // Directed table: each requester slot k carries addr^k / data^(k<<4)
    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].req, {4{tbl[i].addr}} ^ {7'd3, 7'd2, 7'd1, 7'd0}, {4{tbl[i].rw}},
          {4{tbl[i].data}} ^ {8'h30, 8'h20, 8'h10, 8'h00}, tbl[i].nack, tbl[i].mrd,
          tbl[i].lat, tbl[i].exp_w, tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
    end

    // All four requesting continuously from reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 28'($urandom), 4'b0000, $urandom, 1'b0, 8'h00, 3, rr_exp[i], 8'h00, 1'b0, 1'b1);
    end
    bus.i_req = '0;

    // Master busy blocks arbitration
    bus.i_m_busy = 1'b1;
    bus.i_req    = 4'b0010;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.o_gnt != 0) seen = 1; end
    chk("busy_no_gnt", seen, 0);
    bus.i_m_busy = 1'b0;
    txn(4'b0010, 28'h1234567, 4'b0000, 32'hCAFEF00D, 1'b0, 8'h00, 2, 1, 8'h00, 1'b0, 1'b0);

    // Stray master completions in IDLE and ISSUE are ignored
    @(negedge clk);
    bus.i_m_done = 1'b1;
    @(negedge clk);
    bus.i_m_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", {bus.o_done, bus.o_gnt}, 0);
    bus.i_req = 4'b0001;
    wait_gnt();
    bus.i_req    = 4'b0000;
    bus.i_m_done = 1'b1;
    @(negedge clk);
    bus.i_m_done = 1'b0;
    chk("issue_done_ignored", {bus.o_done, bus.o_gnt}, {4'b0000, 4'b0001});
    repeat (2) @(negedge clk);
    bus.i_m_done = 1'b1;
    @(negedge clk);
    bus.i_m_done = 1'b0;
    chk("done_after_ignore", bus.o_done, 4'b0001);
    mlast = 0;

    // Reset in WAIT aborts silently, then requester 0 has priority again
    bus.i_req = 4'b0100;
    wait_gnt();
    chk("abort_gnt", bus.o_gnt, 4'b0100);
    bus.i_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.i_m_done = 1'b1;
    #1;
    chk("reset_in_wait", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.i_m_done = 1'b0;
    mlast = 3;
    seen = 0;
    repeat (5) begin @(negedge clk); if (bus.o_done != 0) seen = 1; end
    chk("no_done_after_abort", seen, 0);
    txn(4'b1001, 28'h0ABCDEF, 4'b1111, 32'h01020304, 1'b0, 8'h6E,
        3, pick(4'b1001, mlast), 8'h6E, 1'b0, 1'b0);

    // Randomized transactions against the round-robin model
    seen = 0;
    for (int t = 0; t < 60; t++) begin
      rq = 4'($urandom_range(1, 15));
      ad = 28'($urandom);
      dt = $urandom;
      rw = 4'($urandom);
      md = 8'($urandom);
      nk = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.i_m_busy = 1'b1;
        bus.i_req    = rq;
        repeat (3) begin @(negedge clk); if (bus.o_gnt != 0) seen = 1; end
        bus.i_m_busy = 1'b0;
      end
      w = pick(rq, mlast);
      txn(rq, ad, rw, dt, nk, md, $urandom_range(2, 8), w,
          rw[w] ? md : 8'h00, nk, 1'($urandom));
    end
    bus.i_req = '0;
    chk("rand_busy_no_gnt", seen, 0);

    // Master that never completes
    @(negedge clk);
    bus.i_req = 4'b0100;
    w = pick(4'b0100, mlast);
    wait_gnt();
    chk("hang_gnt", bus.o_gnt, 64'd1 << w);
    bus.i_req = '0;
    n = 0;
`ifdef I2C_ARB_TIMEOUT_EN
    while (bus.o_done == 0 && n < 40) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 17);
    chk("timeout_status", {bus.o_done, bus.o_err, bus.o_RD_DATA}, {4'(1 << w), 1'b1, 8'h00});
`else
    seen = 0;
    repeat (1000) begin @(negedge clk); if (bus.o_done != 0) seen = 1; end
    chk("no_timeout", seen, 0);
    bus.i_m_done = 1'b1;
    @(negedge clk);
    bus.i_m_done = 1'b0;
    chk("late_done", bus.o_done, 64'd1 << w);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
